// File: rtl/btn_debounce.sv
// btn_debounce: per-channel synchroniser and stability-count debouncer with press/release strobes.
// Optional press-event counter compiled in with BTN_DEBOUNCE_EVCNT_EN.
module btn_debounce #(
    parameter int N = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYCLES = 1_228_800
) (
    input  logic         adc_clk_i,
    input  logic         adc_rst_i,
    input  logic [N-1:0] btn_i,
    output logic [N-1:0] btn_o,
    output logic [N-1:0] rise_o,
    output logic [N-1:0] fall_o,
    input  logic         evt_clr_i,
    output logic [15:0]  evt_cnt_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0] sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) sync_q <= '0;
        else sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end

    for (genvar k = 0; k < N; k++) begin : g_ch
        logic [CW-1:0] cnt;
        logic lvl, r, f;
        assign btn_o[k]  = lvl;
        assign rise_o[k] = r;
        assign fall_o[k] = f;
        // any sample matching the accepted level restarts the stability count
        always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
            if (adc_rst_i) begin
                cnt <= '0;
                lvl <= 1'b0;
                r   <= 1'b0;
                f   <= 1'b0;
            end else begin
                r <= 1'b0;
                f <= 1'b0;
                if (sync[k] == lvl) cnt <= '0;
                else if (cnt == LAST) begin
                    cnt <= '0;
                    lvl <= sync[k];
                    r   <= sync[k];
                    f   <= ~sync[k];
                end else cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef BTN_DEBOUNCE_EVCNT_EN
    logic [15:0] pop;
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) pop = pop + 16'(rise_o[i]);
    end
    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) evt_cnt_o <= '0;
        else evt_cnt_o <= evt_clr_i ? 16'h0000 : evt_cnt_o + pop;
    end
`else
    logic unused_clr;
    assign unused_clr = evt_clr_i;
    assign evt_cnt_o  = 16'h0000;
`endif
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed checks of btn_debounce with N=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_btn_debounce;
`ifdef BTN_DEBOUNCE_EVCNT_EN
    localparam logic EVCNT = 1'b1;
`else
    localparam logic EVCNT = 1'b0;
`endif
    logic clk = 1'b0, rst, clr;
    logic [7:0] btn, btn_o, rise_o, fall_o;
    logic [15:0] evt;
    int total = 0, bad = 0;

    btn_debounce #(.N(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .adc_clk_i(clk), .adc_rst_i(rst), .btn_i(btn), .btn_o(btn_o),
        .rise_o(rise_o), .fall_o(fall_o), .evt_clr_i(clr), .evt_cnt_o(evt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ev(input logic [15:0] v);
        return EVCNT ? v : 16'h0000;
    endfunction

    initial begin
        rst = 1'b1; btn = 8'hFF; clr = 1'b0;
        tick(3);
        chk("rst_btn", btn_o, 0); chk("rst_rise", rise_o, 0);
        chk("rst_fall", fall_o, 0); chk("rst_evt", evt, 0);
        rst = 1'b0;
        tick(5); chk("rel_pre", btn_o, 0);
        tick(1); chk("rel_btn", btn_o, 8'hFF); chk("rel_rise", rise_o, 8'hFF); chk("rel_fall", fall_o, 0);
        tick(1); chk("rel_rise_end", rise_o, 0); chk("rel_evt", evt, ev(8)); chk("rel_hold", btn_o, 8'hFF);
        btn = 8'h00;
        tick(5); chk("all_off_pre", btn_o, 8'hFF);
        tick(1); chk("all_off_btn", btn_o, 0); chk("all_off_fall", fall_o, 8'hFF); chk("all_off_rise", rise_o, 0);
        tick(1); chk("all_off_fall_end", fall_o, 0); chk("all_off_evt", evt, ev(8));
        for (int c = 0; c < 30; c++) begin
            btn = {7'b0, ((c / 3) % 2 == 0)};
            tick(1);
            chk("bounce", {btn_o[0], rise_o[0], fall_o[0]}, 0);
        end
        btn = 8'h00;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            chk("bounce_settle", {btn_o[0], rise_o[0], fall_o[0]}, 0);
        end
        btn = 8'h08;
        tick(5); chk("b3_pre", btn_o, 0);
        tick(1); chk("b3_btn", btn_o, 8'h08); chk("b3_rise", rise_o, 8'h08);
        tick(1); chk("b3_rise_end", rise_o, 0); chk("b3_evt", evt, ev(9));
        tick(3);
        btn = 8'h00;
        tick(5); chk("b3_rel_pre", btn_o, 8'h08);
        tick(1); chk("b3_rel_btn", btn_o, 0); chk("b3_fall", fall_o, 8'h08); chk("b3_no_rise", rise_o, 0);
        tick(1); chk("b3_fall_end", fall_o, 0); chk("b3_evt_hold", evt, ev(9));
        btn = 8'h07;
        tick(5); chk("sim_pre", btn_o, 0);
        tick(1); chk("sim_rise", rise_o, 8'h07); chk("sim_btn", btn_o, 8'h07);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("sim_clr_evt", evt, 0); chk("sim_rise_end", rise_o, 0);
        tick(1); chk("sim_clr_hold", evt, 0);
        btn = 8'h17;
        tick(6); chk("b4_rise", rise_o, 8'h10);
        tick(1); chk("b4_evt", evt, ev(1));
        btn = 8'h37;
        tick(5); chk("mid_pre", btn_o, 8'h17);
        rst = 1'b1;
        #1; chk("mid_rst_btn", btn_o, 0);
        tick(2); chk("mid_rst_evt", evt, 0); chk("mid_rst_rise", rise_o, 0);
        rst = 1'b0;
        tick(5); chk("mid_rel_pre", btn_o, 0);
        tick(1); chk("mid_rel_btn", btn_o, 8'h37); chk("mid_rel_rise", rise_o, 8'h37);
        tick(1); chk("mid_rel_evt", evt, ev(5)); chk("mid_rise_end", rise_o, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/btn_debounce.md
# btn_debounce

Pushbutton/switch input conditioner for the board's user inputs, in the `adc_clk` domain alongside the LED drivers. It synchronises up to 8 asynchronous mechanical inputs and debounces each one with a per-channel stability counter. It outputs clean levels plus one-cycle press/release strobes. An optional press-event counter can be compiled in for diagnostics.

## Interface
- `N`, 8: number of input channels (1..8).
- `SYNC_STAGES`, 2: synchroniser flops per channel (>= 2).
- `DEBOUNCE_CYCLES`, 1_228_800: consecutive stable samples required to accept a change. The default is 10 ms at 122.88 MHz. Must be >= 1.

Ports:
- `adc_clk_i`, in, 1: ADC-derived system clock, 122.88 MHz; all logic is on its rising edge.
- `adc_rst_i`, in, 1: reset, asynchronous, active-high.
- `btn_i`, in, N: raw asynchronous button/switch levels, 1 = pressed.
- `btn_o`, out, N: debounced level.
- `rise_o`, out, N: one-cycle strobe on an accepted 0→1 change.
- `fall_o`, out, N: one-cycle strobe on an accepted 1→0 change.
- `evt_clr_i`, in, 1: synchronous clear of `evt_cnt_o`.
- `evt_cnt_o`, out, 16: total accepted press events across all channels.

## Operation
- Per channel, `btn_i[k]` passes through a SYNC_STAGES-deep flop chain; the last stage is `sync[k]`.
- Per channel, there is a stability counter `cnt[k]` of width $clog2(DEBOUNCE_CYCLES+1).
- When `sync[k] == btn_o[k]`:
  - `cnt[k]` <= 0.
- When `sync[k] != btn_o[k]` and `cnt[k] < DEBOUNCE_CYCLES-1`:
  - `cnt[k]` <= `cnt[k]+1`.
- When `sync[k] != btn_o[k]` and `cnt[k] == DEBOUNCE_CYCLES-1`:
  - `btn_o[k]` <= `sync[k]`.
  - `cnt[k]` <= 0.
  - `rise_o[k]` or `fall_o[k]` is set for exactly one cycle, registered and coincident with the `btn_o` change.
- Any single sample matching `btn_o[k]` restarts the count (no hysteresis memory).
- Channels are fully independent. Simultaneous accepted changes on several channels each produce their own strobe in the same cycle.
- `rise_o[k]` and `fall_o[k]` are never both high.
- `evt_cnt_o` (feature enabled): each cycle it adds popcount(`rise_o` as registered that cycle), modulo 2^16, wrapping 0xFFFF→0x0000.
- `evt_clr_i` has priority: in a cycle with `evt_clr_i=1`, the count becomes 0 and any rises in that cycle are not counted.
- Reset values: synchroniser flops 0, `cnt` 0, `btn_o` 0, `rise_o` 0, `fall_o` 0, `evt_cnt_o` 0.
- Reset asserted mid-debounce discards partial counts. After release, a held input needs a full DEBOUNCE_CYCLES again.
- An input held at 1 through reset is accepted as a press, with a `rise_o` strobe, after release.

## Timing
- Latency: a step on `btn_i` (meeting setup) appears on `btn_o` on the (SYNC_STAGES + DEBOUNCE_CYCLES)-th rising edge after the change. The default is 2+4 = 6 edges when DEBOUNCE_CYCLES=4.
- Strobes are valid in the same cycle `btn_o` changes and last one cycle.
- `evt_cnt_o` updates one cycle after the corresponding `rise_o` strobe.
- Minimum accepted pulse width: DEBOUNCE_CYCLES cycles at the synchroniser output. Shorter pulses produce no output activity.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `BTN_DEBOUNCE_EVCNT_EN` defined:
  - The 16-bit event counter and clear logic are built as described.
- `BTN_DEBOUNCE_EVCNT_EN` undefined:
  - `evt_cnt_o` is tied to 16'h0000 and `evt_clr_i` is ignored.
  - No counter flops are inferred.
  - All other behaviour is identical.

## Test plan
All scenarios use N=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, macro defined unless stated.
- Reset release with all inputs pressed: `btn_i`=0xFF held through reset → outputs all 0 during reset. On the 6th edge after release, `btn_o`=0xFF and `rise_o`=0xFF for one cycle. One cycle later, `evt_cnt_o`=8.
- Bounce rejection: `btn_i[0]` toggles every 3 cycles for 30 cycles, then settles at 0 → `btn_o[0]`=0 throughout, with no `rise_o[0]` or `fall_o[0]` pulse.
- Clean press/release on bit 3: held high 10 cycles, then low → `btn_o[3]` rises 6 edges after the press with a one-cycle `rise_o[3]`. It falls 6 edges after the release with a one-cycle `fall_o[3]`. `evt_cnt_o` increments by 1.
- Simultaneous rises with clear: bits 0,1,2 pressed together, with `evt_clr_i`=1 on the strobe cycle → `rise_o`=0x07 and `evt_cnt_o`=0. A later press of bit 4 → `evt_cnt_o`=1.
- Reset mid-operation: `btn_i[5]` high, `adc_rst_i` pulsed when `cnt[5]`=3 → `btn_o[5]` stays 0. After release, `btn_o[5]` rises exactly 6 edges later.
- Macro undefined: rerun the first scenario → `btn_o` and `rise_o` behave the same, and `evt_cnt_o` stays 0x0000.
